// File: rtl/metronome_pkg.sv
// rtl/metronome_pkg.sv - shared constants for the metronome UART command path
// Purpose: command characters, RX FSM state encoding and bit-timing helper.
// Ports: none (package).
package metronome_pkg;

  // Command characters accepted from the host
  localparam logic [7:0] CMD_CHR_PLUS1   = 8'h2B;  // '+'
  localparam logic [7:0] CMD_CHR_PLUS5   = 8'h3E;  // '>'
  localparam logic [7:0] CMD_CHR_MINUS1  = 8'h2D;  // '-'
  localparam logic [7:0] CMD_CHR_MINUS5  = 8'h3C;  // '<'
  localparam logic [7:0] CMD_CHR_RESET_U = 8'h52;  // 'R'
  localparam logic [7:0] CMD_CHR_RESET_L = 8'h72;  // 'r'

  // RX state encoding
  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = RX_IDLE,
    S_START = RX_START,
    S_DATA  = RX_DATA,
    S_STOP  = RX_STOP,
    S_BREAK = RX_BREAK
  } rx_state_e;

  // Clock cycles per bit, rounded to nearest
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 UART receiver with input synchroniser
// Purpose: synchronise the RX pin, time bits and deframe bytes.
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_rx              asynchronous serial input (idles high)
//   o_data            last byte received with a valid stop bit
//   o_valid           one-cycle strobe when o_data updates
//   o_frame_err       one-cycle strobe when the stop bit samples 0
module uart_rx_8n1
  import metronome_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TW           = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1    = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] FULL_M1    = TW'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  rx_state_e              state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Synchroniser presets to idle-high so a low line during reset is not a start
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) sync_q <= '1;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[7:1]};  // LSB arrives first
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Held-low line: wait for idle so only one frame error is reported
        timer_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART ASCII command to metronome pulse decoder
// Purpose: receive 8N1 bytes and turn command characters into one-cycle pulses.
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_uart_rx         asynchronous serial input (idles high)
//   o_rx_data/o_rx_valid/o_frame_err  raw receiver probes
//   o_unknown_cmd     valid byte that is not a command
//   o_cmd_*           one-cycle command pulses, the cycle after o_rx_valid
module uart_cmd_decoder
  import metronome_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_unknown_cmd,
  output logic       o_cmd_reset,
  output logic       o_cmd_plus_1,
  output logic       o_cmd_plus_5,
  output logic       o_cmd_minus_1,
  output logic       o_cmd_minus_5
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       unk_q, rst_q, p1_q, p5_q, m1_q, m5_q;
  logic       unk_d, rst_d, p1_d, p5_d, m1_d, m5_d;

  uart_rx_8n1 #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD_RATE   (BAUD_RATE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_rx        (i_uart_rx),
    .o_data      (rx_data),
    .o_valid     (rx_valid),
    .o_frame_err (o_frame_err)
  );

  always_comb begin
    unk_d = 1'b0;
    rst_d = 1'b0;
    p1_d  = 1'b0;
    p5_d  = 1'b0;
    m1_d  = 1'b0;
    m5_d  = 1'b0;
    if (rx_valid) begin
      case (rx_data)
        CMD_CHR_PLUS1:   p1_d  = 1'b1;
        CMD_CHR_PLUS5:   p5_d  = 1'b1;
        CMD_CHR_MINUS1:  m1_d  = 1'b1;
        CMD_CHR_MINUS5:  m5_d  = 1'b1;
        CMD_CHR_RESET_U,
        CMD_CHR_RESET_L: rst_d = 1'b1;
        default:         unk_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      unk_q <= 1'b0;
      rst_q <= 1'b0;
      p1_q  <= 1'b0;
      p5_q  <= 1'b0;
      m1_q  <= 1'b0;
      m5_q  <= 1'b0;
    end else begin
      unk_q <= unk_d;
      rst_q <= rst_d;
      p1_q  <= p1_d;
      p5_q  <= p5_d;
      m1_q  <= m1_d;
      m5_q  <= m5_d;
    end
  end

  assign o_rx_data     = rx_data;
  assign o_rx_valid    = rx_valid;
  assign o_unknown_cmd = unk_q;
  assign o_cmd_reset   = rst_q;
  assign o_cmd_plus_1  = p1_q;
  assign o_cmd_plus_5  = p5_q;
  assign o_cmd_minus_1 = m1_q;
  assign o_cmd_minus_5 = m5_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

  localparam int BIT = 434;

  localparam int C_VAL = 0;
  localparam int C_FERR = 1;
  localparam int C_UNK = 2;
  localparam int C_RST = 3;
  localparam int C_P1 = 4;
  localparam int C_P5 = 5;
  localparam int C_M1 = 6;
  localparam int C_M5 = 7;
  localparam int C_STRETCH = 8;
  localparam int C_LATE = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_valid, o_frame_err, o_unknown_cmd;
  logic       o_cmd_reset, o_cmd_plus_1, o_cmd_plus_5, o_cmd_minus_1, o_cmd_minus_5;

  int n_checks = 0;
  int n_errs = 0;
  int cnt[10];
  int base[10];
  int cyc = 0;
  int t_p5 = 0, t_m5 = 0, t_rst = 0;
  logic [7:0] last_data = 8'h00;
  logic [4:0] prev_cmd = '0;
  logic       prev_valid = 1'b0;

  uart_cmd_decoder dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_uart_rx     (rx),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .o_frame_err   (o_frame_err),
    .o_unknown_cmd (o_unknown_cmd),
    .o_cmd_reset   (o_cmd_reset),
    .o_cmd_plus_1  (o_cmd_plus_1),
    .o_cmd_plus_5  (o_cmd_plus_5),
    .o_cmd_minus_1 (o_cmd_minus_1),
    .o_cmd_minus_5 (o_cmd_minus_5)
  );

  always #10 clk = ~clk;

  initial for (int i = 0; i < 10; i++) cnt[i] = 0;

  // Event monitor sampled on the falling edge
  always @(negedge clk) begin
    logic [4:0] cmd;
    cmd = {o_cmd_reset, o_cmd_plus_1, o_cmd_plus_5, o_cmd_minus_1, o_cmd_minus_5};
    cyc = cyc + 1;
    if (o_rx_valid) begin cnt[C_VAL]++; last_data = o_rx_data; end
    if (o_frame_err) cnt[C_FERR]++;
    if (o_unknown_cmd) cnt[C_UNK]++;
    if (o_cmd_reset) begin cnt[C_RST]++; t_rst = cyc; end
    if (o_cmd_plus_1) cnt[C_P1]++;
    if (o_cmd_plus_5) begin cnt[C_P5]++; t_p5 = cyc; end
    if (o_cmd_minus_1) cnt[C_M1]++;
    if (o_cmd_minus_5) begin cnt[C_M5]++; t_m5 = cyc; end
    if ((cmd & prev_cmd) != 0) cnt[C_STRETCH]++;
    if ((cmd != 0 || o_unknown_cmd) && !prev_valid) cnt[C_LATE]++;
    prev_cmd = cmd;
    prev_valid = o_rx_valid;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 10; i++) base[i] = cnt[i];
  endtask

  function automatic int d(input int idx);
    return cnt[idx] - base[idx];
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_clk(BIT);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  function automatic logic [14:0] all_outs();
    return {o_rx_data, o_rx_valid, o_frame_err, o_unknown_cmd, o_cmd_reset,
            o_cmd_plus_1, o_cmd_plus_5, o_cmd_minus_1, o_cmd_minus_5};
  endfunction

  initial begin
    logic [7:0] b;
    int diff;

    // Reset state
    wait_clk(5);
    check_val("reset_outputs", 32'(all_outs()), 32'h0);
    rst_n = 1'b1;
    wait_clk(2 * BIT);

    // Single '+'
    snap();
    send_byte(8'h2B, 1'b1);
    wait_clk(20);
    check_val("plus_valid", d(C_VAL), 1);
    check_val("plus_data", last_data, 8'h2B);
    check_val("plus_p1", d(C_P1), 1);
    check_val("plus_others", d(C_P5) + d(C_M1) + d(C_M5) + d(C_RST) + d(C_UNK) + d(C_FERR), 0);

    // Back-to-back '>' '<' 'r' with no idle gap
    snap();
    send_byte(8'h3E, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h72, 1'b1);
    wait_clk(20);
    check_val("b2b_p5", d(C_P5), 1);
    check_val("b2b_m5", d(C_M5), 1);
    check_val("b2b_rst", d(C_RST), 1);
    check_val("b2b_ferr", d(C_FERR), 0);
    diff = t_m5 - t_p5;
    check_val($sformatf("b2b_gap1_%0d", diff), 32'(diff >= 4320 && diff <= 4360), 1);
    diff = t_rst - t_m5;
    check_val($sformatf("b2b_gap2_%0d", diff), 32'(diff >= 4320 && diff <= 4360), 1);

    // Unknown bytes 'A' then CR
    snap();
    send_byte(8'h41, 1'b1);
    wait_clk(20);
    check_val("unk_data_a", last_data, 8'h41);
    send_byte(8'h0D, 1'b1);
    wait_clk(20);
    check_val("unk_data_cr", last_data, 8'h0D);
    check_val("unk_count", d(C_UNK), 2);
    check_val("unk_no_cmd", d(C_P1) + d(C_P5) + d(C_M1) + d(C_M5) + d(C_RST), 0);

    // Frame error with held-low break, then '-'
    snap();
    send_byte(8'h2D, 1'b0);
    wait_clk(3 * BIT);
    rx = 1'b1;
    wait_clk(BIT);
    check_val("ferr_count", d(C_FERR), 1);
    check_val("ferr_no_valid", d(C_VAL), 0);
    check_val("ferr_data_kept", o_rx_data, 8'h0D);
    send_byte(8'h2D, 1'b1);
    wait_clk(20);
    check_val("ferr_m1", d(C_M1), 1);
    check_val("ferr_after_data", last_data, 8'h2D);
    check_val("ferr_total", d(C_FERR), 1);

    // 100 ns glitch on idle line, then '+' to show return to idle
    snap();
    rx = 1'b0;
    wait_clk(5);
    rx = 1'b1;
    wait_clk(2 * BIT);
    check_val("glitch_strobes", d(C_VAL) + d(C_FERR) + d(C_UNK), 0);
    send_byte(8'h2B, 1'b1);
    wait_clk(20);
    check_val("glitch_then_p1", d(C_P1), 1);

    // Reset during bit 4 of 0x2B, then '>'
    snap();
    b = 8'h2B;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    wait_clk(200);
    rst_n = 1'b0;
    wait_clk(3);
    check_val("midreset_outputs", 32'({o_rx_valid, o_frame_err, o_unknown_cmd, o_cmd_reset,
              o_cmd_plus_1, o_cmd_plus_5, o_cmd_minus_1, o_cmd_minus_5}), 32'h0);
    rx = 1'b1;
    wait_clk(7);
    rst_n = 1'b1;
    wait_clk(2 * BIT);
    check_val("midreset_no_strobe", d(C_VAL) + d(C_FERR) + d(C_UNK) + d(C_P1), 0);
    send_byte(8'h3E, 1'b1);
    wait_clk(20);
    check_val("midreset_p5", d(C_P5), 1);
    check_val("midreset_valid", d(C_VAL), 1);
    check_val("midreset_p1", d(C_P1), 0);
    check_val("midreset_data", last_data, 8'h3E);

    // Global pulse-shape properties
    check_val("no_stretch", cnt[C_STRETCH], 0);
    check_val("decode_latency", cnt[C_LATE], 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
